// File: rtl/jfpjc_pkg.sv
// Shared constants, state encoding and helpers for the JPEG entropy bit packer.
//   MARKER_PREFIX : byte value that must be followed by a stuffed byte
//   STUFF_BYTE    : byte inserted after every MARKER_PREFIX byte
//   MAX_CODE_LEN  : longest Huffman/amplitude code accepted in one word
package jfpjc_pkg;

   localparam logic [7:0]  MARKER_PREFIX = 8'hFF;
   localparam logic [7:0]  STUFF_BYTE    = 8'h00;
   localparam int unsigned MAX_CODE_LEN  = 16;

   localparam int unsigned ACC_W  = 32;
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned CODE_W = 16;
   localparam int unsigned LEN_W  = 5;

   // Packer state encoding
   localparam logic [1:0] ST_RUN         = 2'd0;
   localparam logic [1:0] ST_FLUSH_PAD   = 2'd1;
   localparam logic [1:0] ST_FLUSH_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE        = 2'd3;

   // A right-justified code word and its length in bits
   typedef struct packed {
      logic [CODE_W-1:0] bits;
      logic [LEN_W-1:0]  len;
   } code_t;

   // Lengths above MAX_CODE_LEN saturate
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      return (len > LEN_W'(MAX_CODE_LEN)) ? LEN_W'(MAX_CODE_LEN) : len;
   endfunction

   // Zero every bit at or above position len
   function automatic logic [CODE_W-1:0] mask_code(input logic [CODE_W-1:0] bits,
                                                   input logic [LEN_W-1:0]  len);
      return bits & CODE_W'((17'd1 << len) - 17'd1);
   endfunction

endpackage

// File: rtl/jpeg_bit_packer.sv
// JPEG entropy-coded segment bit packer.
// Packs variable-length codes MSB-first into bytes, inserts 0x00 after every
// emitted 0xFF (when STUFF_ENABLE != 0) and supports a pad-with-ones flush.
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   in_valid/in_ready     : code word handshake (in_ready is combinational
//                           from registered state only)
//   in_bits[15:0]         : right-justified code, masked to in_length bits
//   in_length[4:0]        : code length 0..16 (larger values saturate at 16)
//   flush / flush_done    : pad-and-drain request / one-cycle completion pulse
//   out_valid/out_ready   : output byte handshake
//   out_byte[7:0]         : packed, stuffed byte stream
//   busy                  : state not RUN or any bit/byte still pending
module jpeg_bit_packer
   import jfpjc_pkg::*;
#(
   parameter int unsigned STUFF_ENABLE = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_bits,
   input  logic [LEN_W-1:0]  in_length,
   input  logic              flush,
   output logic              flush_done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_byte,
   output logic              busy
);

   logic [1:0]       state, state_nx;
   logic [ACC_W-1:0] acc, acc_nx;
   logic [CNT_W-1:0] bit_count, bit_count_nx;
   logic             stuff_pending, stuff_pending_nx;
   logic             out_valid_nx;
   logic [7:0]       out_byte_nx;
   logic             flush_done_nx;
   logic             busy_nx;

   code_t            ins;
   logic [2:0]       pad_len;
   logic [ACC_W-1:0] ins_word;
   logic [ACC_W-1:0] acc_sum;
   logic [CNT_W-1:0] count_sum;
   logic             accept;
   logic             load_slot;

   // Room for a full 16-bit code is guaranteed while bit_count <= 16
   assign in_ready = (state == ST_RUN) && (bit_count <= CNT_W'(MAX_CODE_LEN));

   // Next-state, datapath and output computation
   always_comb begin
      state_nx         = state;
      acc_nx           = acc;
      bit_count_nx     = bit_count;
      stuff_pending_nx = stuff_pending;
      out_valid_nx     = out_valid;
      out_byte_nx      = out_byte;
      ins              = '0;
      pad_len          = 3'd0 - bit_count[2:0];
      accept           = in_valid && in_ready;
      load_slot        = !out_valid || out_ready;

      // Insert either the accepted code or the flush padding ones
      if (accept) begin
         ins.bits = in_bits;
         ins.len  = clamp_len(in_length);
      end else if (state == ST_FLUSH_PAD) begin
         ins.bits = '1;
         ins.len  = LEN_W'(pad_len);
      end

      // Left-align the code at bit 31, then move it below the valid bits
      ins_word  = (ACC_W'(mask_code(ins.bits, ins.len)) << (6'd32 - 6'(ins.len))) >> bit_count;
      acc_sum   = acc | ins_word;
      count_sum = bit_count + CNT_W'(ins.len);

      acc_nx       = acc_sum;
      bit_count_nx = count_sum;

      // Output register: a pending stuff byte wins over accumulator bytes
      if (load_slot) begin
         if (stuff_pending) begin
            out_byte_nx      = STUFF_BYTE;
            out_valid_nx     = 1'b1;
            stuff_pending_nx = 1'b0;
         end else if (bit_count >= CNT_W'(8)) begin
            out_byte_nx      = acc[ACC_W-1 -: 8];
            out_valid_nx     = 1'b1;
            stuff_pending_nx = (STUFF_ENABLE != 0) && (acc[ACC_W-1 -: 8] == MARKER_PREFIX);
            acc_nx           = acc_sum << 8;
            bit_count_nx     = count_sum - CNT_W'(8);
         end else begin
            out_valid_nx = 1'b0;
         end
      end

      // Flush sequencing
      case (state)
         ST_RUN: begin
            if (flush) state_nx = ST_FLUSH_PAD;
         end
         ST_FLUSH_PAD: begin
            state_nx = ST_FLUSH_DRAIN;
         end
         ST_FLUSH_DRAIN: begin
            if (bit_count == '0 && !stuff_pending && !out_valid) state_nx = ST_DONE;
         end
         ST_DONE: begin
            state_nx     = ST_RUN;
            acc_nx       = '0;
            bit_count_nx = '0;
         end
         default: begin
            state_nx = ST_RUN;
         end
      endcase

      flush_done_nx = (state_nx == ST_DONE);
      busy_nx       = (state_nx != ST_RUN) || (bit_count_nx != '0) ||
                      stuff_pending_nx || out_valid_nx;
   end

   // State and output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_RUN;
         acc           <= '0;
         bit_count     <= '0;
         stuff_pending <= 1'b0;
         out_valid     <= 1'b0;
         out_byte      <= 8'h00;
         flush_done    <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_nx;
         acc           <= acc_nx;
         bit_count     <= bit_count_nx;
         stuff_pending <= stuff_pending_nx;
         out_valid     <= out_valid_nx;
         out_byte      <= out_byte_nx;
         flush_done    <= flush_done_nx;
         busy          <= busy_nx;
      end
   end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Self-checking bench for jpeg_bit_packer: table of code-word groups with
// expected bytes, hand sequences for multi-cycle corners, and a random run
// checked against a bit-serial reference model through a byte scoreboard.
module tb_jpeg_bit_packer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_bits;
   logic [4:0]  in_length;
   logic        flush;
   logic        flush_done;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_byte;
   logic        busy;

   logic        ready_cmd;
   logic        rr_mode;
   logic        rr_bit;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];

   int          m_n;
   logic [7:0]  m_cur;

   jpeg_bit_packer dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_bits    (in_bits),
      .in_length  (in_length),
      .flush      (flush),
      .flush_done (flush_done),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_byte   (out_byte),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   assign out_ready = rr_mode ? rr_bit : ready_cmd;

   always @(posedge clock) rr_bit <= ($urandom_range(0, 3) != 0);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Scoreboard: every accepted output byte pops one expected byte
   always @(negedge clock) begin
      if (reset_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", out_byte);
         end else begin
            check("out_byte", 32'(out_byte), 32'(exp_q.pop_front()));
         end
      end
   end

   // Bit-serial reference model
   task automatic model_bit(input logic bv);
      m_cur = {m_cur[6:0], bv};
      m_n++;
      if (m_n == 8) begin
         exp_q.push_back(m_cur);
         if (m_cur == 8'hFF) exp_q.push_back(8'h00);
         m_n = 0;
      end
   endtask

   task automatic model_push(input logic [15:0] b, input logic [4:0] l);
      int len;
      len = (l > 5'd16) ? 16 : int'(l);
      for (int i = len - 1; i >= 0; i--) model_bit(b[i]);
   endtask

   task automatic model_pad();
      while (m_n != 0) model_bit(1'b1);
   endtask

   // Offer one word (optionally with flush) until accepted; ends at posedge+1
   task automatic send(input logic [15:0] b, input logic [4:0] l, input logic with_flush);
      bit ok;
      ok        = 1'b0;
      in_bits   = b;
      in_length = l;
      in_valid  = 1'b1;
      flush     = with_flush;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clock);
         if (in_ready) ok = 1'b1;
         @(posedge clock);
         #1;
      end
      in_valid = 1'b0;
      flush    = 1'b0;
      if (!ok) fail("send_accept");
   endtask

   // Called at posedge+1 right after flush was sampled; returns edges to pulse
   task automatic wait_flush_done(output int n);
      bit seen;
      seen = 1'b0;
      n    = 0;
      for (int t = 0; t < 400 && !seen; t++) begin
         if (flush_done) seen = 1'b1;
         else begin
            @(posedge clock);
            #1;
            n++;
         end
      end
      if (!seen) fail("flush_done_wait");
      else begin
         @(posedge clock);
         #1;
         check("flush_done_one_cycle", 32'(flush_done), 32'd0);
         check("in_ready_after_done", 32'(in_ready), 32'd1);
      end
   endtask

   task automatic do_flush(output int n);
      flush = 1'b1;
      @(posedge clock);
      #1;
      flush = 1'b0;
      wait_flush_done(n);
   endtask

   task automatic wait_empty(input string name);
      for (int t = 0; t < 400 && !(exp_q.size() == 0 && !busy); t++) begin
         @(posedge clock);
         #1;
      end
      check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      check({name, "_idle"}, 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic [15:0] b0;
      logic [4:0]  l0;
      logic [15:0] b1;
      logic [4:0]  l1;
      logic        merge;
      int          n;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int          lat;
      int          n_acc;
      logic [31:0] e;
      logic [15:0] rb;
      logic [4:0]  rl;

      vecs[0]  = '{16'h0005,  5'd3, 16'h0019,  5'd5, 1'b0, 1, 32'hB9000000, "b9"};
      vecs[1]  = '{16'hFFFF, 5'd16, 16'h0000,  5'd0, 1'b0, 4, 32'hFF00FF00, "ffff_stuff"};
      vecs[2]  = '{16'h0001,  5'd2, 16'h0000,  5'd0, 1'b0, 1, 32'h7F000000, "pad_7f"};
      vecs[3]  = '{16'h0007,  5'd3, 16'h0000,  5'd0, 1'b0, 2, 32'hFF000000, "pad_ff_stuff"};
      vecs[4]  = '{16'hABC5,  5'd4, 16'h0000,  5'd0, 1'b0, 1, 32'h5F000000, "mask"};
      vecs[5]  = '{16'h1234, 5'd31, 16'h0000,  5'd0, 1'b0, 2, 32'h12340000, "len_clamp"};
      vecs[6]  = '{16'hFFFF,  5'd0, 16'h00A5,  5'd8, 1'b0, 1, 32'hA5000000, "len_zero"};
      vecs[7]  = '{16'h0ABC, 5'd12, 16'h0123, 5'd12, 1'b0, 3, 32'hABC12300, "cross"};
      vecs[8]  = '{16'h0000,  5'd7, 16'h0000,  5'd0, 1'b0, 1, 32'h01000000, "pad_one"};
      vecs[9]  = '{16'hFF00, 5'd16, 16'h0000,  5'd0, 1'b0, 3, 32'hFF000000, "ff00"};
      vecs[10] = '{16'h0005,  5'd3, 16'h0002,  5'd2, 1'b1, 1, 32'hB7000000, "flush_merge"};
      vecs[11] = '{16'hA5A5, 5'd16, 16'h5A5A, 5'd16, 1'b1, 4, 32'hA5A55A5A, "flush_merge_full"};

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_bits   = '0;
      in_length = '0;
      flush     = 1'b0;
      ready_cmd = 1'b1;
      rr_mode   = 1'b0;
      m_n       = 0;
      m_cur     = '0;

      // Reset values
      repeat (2) @(posedge clock);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_byte", 32'(out_byte), 32'd0);
      check("rst_flush_done", 32'(flush_done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      @(negedge clock);
      check("in_ready_after_reset", 32'(in_ready), 32'd1);
      @(posedge clock);
      #1;

      // Table: each group is followed by a flush so groups are independent
      foreach (vecs[k]) begin
         e = vecs[k].exp;
         for (int i = 0; i < vecs[k].n; i++) begin
            exp_q.push_back(e[31:24]);
            e = e << 8;
         end
         send(vecs[k].b0, vecs[k].l0, 1'b0);
         send(vecs[k].b1, vecs[k].l1, vecs[k].merge);
         if (vecs[k].merge) wait_flush_done(lat);
         else do_flush(lat);
         check({vecs[k].name, "_drained"}, 32'(exp_q.size()), 32'd0);
      end

      // Empty flush: no bytes, flush_done two edges after the flush edge
      do_flush(lat);
      check("empty_flush_latency", 32'(lat), 32'd2);
      check("empty_flush_no_bytes", 32'(exp_q.size()), 32'd0);

      // 0xFFFF: FF,00,FF,00 on consecutive cycles
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      send(16'hFFFF, 5'd16, 1'b0);
      for (int t = 0; t < 20 && !out_valid; t++) @(negedge clock);
      for (int i = 0; i < 4; i++) begin
         check("consecutive_valid", 32'(out_valid), 32'd1);
         @(negedge clock);
      end
      check("consecutive_end", 32'(out_valid), 32'd0);
      @(posedge clock);
      #1;
      wait_empty("consecutive");

      // Backpressure: exactly two accepts, output held stable
      ready_cmd = 1'b0;
      in_bits   = 16'h1234;
      in_length = 5'd16;
      in_valid  = 1'b1;
      n_acc     = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (in_ready) n_acc++;
         @(posedge clock);
         #1;
      end
      in_valid = 1'b0;
      check("stall_accepts", 32'(n_acc), 32'd2);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_byte", 32'(out_byte), 32'h12);
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h34);
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h34);
      ready_cmd = 1'b1;
      wait_empty("stall");

      // Reset mid-stream with 13 bits held and a byte waiting
      ready_cmd = 1'b0;
      send(16'hABCD, 5'd16, 1'b0);
      @(posedge clock);
      #1;
      send(16'h001F, 5'd5, 1'b0);
      check("pre_reset_valid", 32'(out_valid), 32'd1);
      check("pre_reset_busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_byte", 32'(out_byte), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(negedge clock);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clock);
      #1;
      ready_cmd = 1'b1;
      exp_q.push_back(8'h5A);
      send(16'h005A, 5'd8, 1'b0);
      wait_empty("post_reset");

      // Random words and random downstream stalls against the model
      rr_mode = 1'b1;
      m_n     = 0;
      for (int w = 0; w < 60; w++) begin
         rb = 16'($urandom);
         rl = 5'($urandom_range(0, 20));
         model_push(rb, rl);
         send(rb, rl, 1'b0);
         if (w % 15 == 14) begin
            model_pad();
            do_flush(lat);
         end
      end
      model_pad();
      do_flush(lat);
      rr_mode = 1'b0;
      wait_empty("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
